// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width default and the byte-packer FSM states.
package uart_pkg;

    // Default byte width shared by uart_rx, uart_tx and the packer
    localparam int W_BYTE_DEF = 8;

    // Packer states: collecting bytes, or holding a finished word waiting for OUT
    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } pack_state_t;

    // Byte-index width: at least one bit even for tiny word sizes
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Idle timer: counts cycles while run is high; expire pulses for the one cycle
// in which the count reaches TIMEOUT_CLKS. Clear restarts the count. The count
// saturates so a timer left running does not fire again. TIMEOUT_CLKS=0
// disables the timer entirely.
module uart_idle_timer #(
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic run,
    output logic expire
);

    generate
        if (TIMEOUT_CLKS == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CLKS + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CLKS);

            logic [CW-1:0] cnt;

            // Idle count: clear wins, otherwise advance while running up to LIMIT
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (run && (cnt != LIMIT)) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // Fires on the cycle whose edge takes the count to LIMIT
            assign expire = run && (cnt == (LIMIT - CW'(1)));
        end
    endgenerate

endmodule

// File: rtl/uart_rx_packer.sv
// Packs NUM_BYTES consecutive bytes from uart_rx into one wide word and offers
// it on a valid/ready master port. An assembly register (asm_q) collects bytes
// while the output register (m_data) holds the previous word, so one full word
// can wait while the next is collected. A partial word left idle for
// TIMEOUT_CLKS cycles is discarded to resynchronise framing.
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int W_BYTE       = W_BYTE_DEF,
    parameter int NUM_BYTES    = 4,
    parameter int LSB_FIRST    = 1,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        s_valid,
    input  logic [W_BYTE-1:0]           s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [W_BYTE*NUM_BYTES-1:0] m_data,
    output logic                        overflow,
    output logic                        timeout_pulse,
    input  logic                        clr_flags
);

    localparam int IW = idx_width(NUM_BYTES);
    localparam int WW = W_BYTE * NUM_BYTES;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

    pack_state_t   state;
    logic [IW-1:0] idx;
    logic [WW-1:0] asm_q;

    logic          xfer;
    logic          out_free;
    logic          byte_accept;
    logic          byte_drop;
    logic          expire;
    logic          timer_run;
    logic [IW-1:0] wr_idx;
    logic          last_byte;
    logic [WW-1:0] asm_wr;
    int            slot;

    // Handshake, accept/drop decisions and the assembly word with this byte merged in
    always_comb begin
        xfer        = m_valid && m_ready;
        out_free    = !m_valid || xfer;
        // In PENDING a byte only gets in when the waiting word moves out this cycle
        byte_accept = s_valid && ((state == COLLECT) || xfer);
        byte_drop   = s_valid && (state == PENDING) && !xfer;
        // A byte arriving with the timeout restarts framing at slot 0
        wr_idx      = expire ? '0 : idx;
        last_byte   = (wr_idx == LAST_IDX);
        slot        = (LSB_FIRST != 0) ? int'(wr_idx) : (NUM_BYTES - 1 - int'(wr_idx));
        asm_wr      = asm_q;
        asm_wr[slot*W_BYTE +: W_BYTE] = s_data;
    end

    // Timer only watches a partly assembled word
    assign timer_run = (state == COLLECT) && (idx != '0);

    uart_idle_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_idle_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (byte_accept),
        .run    (timer_run),
        .expire (expire)
    );

    // Packer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= COLLECT;
            idx           <= '0;
            asm_q         <= '0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            overflow      <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= expire;

            // A drop in the same cycle beats the clear
            if (clr_flags) overflow <= 1'b0;
            if (byte_drop) overflow <= 1'b1;

            // Consumer took the word; a load below re-raises valid with no gap
            if (xfer) m_valid <= 1'b0;

            case (state)
                COLLECT: begin
                    if (expire) idx <= '0;
                    if (s_valid) begin
                        asm_q <= asm_wr;
                        if (last_byte) begin
                            idx <= '0;
                            if (out_free) begin
                                m_data  <= asm_wr;
                                m_valid <= 1'b1;
                            end else begin
                                state <= PENDING;
                            end
                        end else begin
                            idx <= wr_idx + IW'(1);
                        end
                    end
                end
                PENDING: begin
                    // idx is 0 here: it wrapped when the pending word completed
                    if (xfer) begin
                        m_data  <= asm_q;
                        m_valid <= 1'b1;
                        state   <= COLLECT;
                        if (s_valid) begin
                            asm_q <= asm_wr;
                            idx   <= IW'(1);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Self-checking bench for uart_rx_packer. Two instances share stimulus: one packs
// LSB-first, the other MSB-first; both use a 20-cycle idle timeout.
module tb_uart_rx_packer;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        m_ready = 1'b0;
    logic        clr_flags = 1'b0;

    logic        m_valid, overflow, timeout_pulse;
    logic [31:0] m_data;
    logic        m_valid_b, overflow_b, timeout_pulse_b;
    logic [31:0] m_data_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_packer #(.W_BYTE(8), .NUM_BYTES(NB), .LSB_FIRST(1), .TIMEOUT_CLKS(20)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .overflow(overflow), .timeout_pulse(timeout_pulse), .clr_flags(clr_flags)
    );

    uart_rx_packer #(.W_BYTE(8), .NUM_BYTES(NB), .LSB_FIRST(0), .TIMEOUT_CLKS(20)) dut_msb (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
        .overflow(overflow_b), .timeout_pulse(timeout_pulse_b), .clr_flags(clr_flags)
    );

    // Reference packing: byte i of a word goes to slot i (LSB-first) or slot NB-1-i
    function automatic logic [31:0] pack(input logic [7:0] b [NB], input bit lsb);
        logic [31:0] w = '0;
        for (int i = 0; i < NB; i++) begin
            if (lsb) w[i*8 +: 8] = b[i];
            else     w[(NB-1-i)*8 +: 8] = b[i];
        end
        return w;
    endfunction

    // The bench lives on the falling edge: inputs set here, one edge per tick
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        n_cmp++;
        if ({m_valid, m_data, overflow, timeout_pulse} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b d=%h o=%b t=%b want all zero", m_valid, m_data, overflow, timeout_pulse);
        end
        n_cmp++;
        if ({m_valid_b, m_data_b} !== 33'd0) begin
            n_bad++;
            $display("FAIL reset_outputs_msb: got v=%b d=%h want zero", m_valid_b, m_data_b);
        end
    endtask

    task automatic test_basic_order();
        logic [7:0] b [NB] = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_ready = 1'b1;
        for (int i = 0; i < NB - 1; i++) send_byte(b[i]);
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL early_valid: got %b want 0", m_valid);
        end
        send_byte(b[NB-1]);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== pack(b, 1'b1)) begin
            n_bad++;
            $display("FAIL lsb_word: got v=%b d=%h want v=1 d=%h", m_valid, m_data, pack(b, 1'b1));
        end
        n_cmp++;
        if (m_valid_b !== 1'b1 || m_data_b !== pack(b, 1'b0)) begin
            n_bad++;
            $display("FAIL msb_word: got v=%b d=%h want v=1 d=%h", m_valid_b, m_data_b, pack(b, 1'b0));
        end
        tick();
        n_cmp++;
        if (m_valid !== 1'b0 || m_valid_b !== 1'b0) begin
            n_bad++;
            $display("FAIL valid_one_cycle: got %b/%b want 0/0", m_valid, m_valid_b);
        end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 32'h04030201 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold: got v=%b d=%h o=%b want v=1 d=04030201 o=0", m_valid, m_data, overflow);
        end
        send_byte(8'hAA);
        n_cmp++;
        if (overflow !== 1'b1 || m_data !== 32'h04030201) begin
            n_bad++;
            $display("FAIL bp_drop: got o=%b d=%h want o=1 d=04030201", overflow, m_data);
        end
        m_ready = 1'b1;
        tick();
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 32'h08070605) begin
            n_bad++;
            $display("FAIL bp_second: got v=%b d=%h want v=1 d=08070605", m_valid, m_data);
        end
        tick();
        m_ready = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: got v=%b want 0", m_valid);
        end
    endtask

    task automatic test_clr_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_initial: got %b want 0", overflow);
        end
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i));
        clr_flags = 1'b1;
        send_byte(8'h55);
        clr_flags = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_vs_drop: got %b want 1", overflow);
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_alone: got %b want 0", overflow);
        end
        m_ready = 1'b1;
        tick();
        n_cmp++;
        if (m_data !== 32'h37363534) begin
            n_bad++;
            $display("FAIL clr_pending_word: got %h want 37363534", m_data);
        end
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        m_ready = 1'b1;
        send_byte(8'hDE);
        send_byte(8'hAD);
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (timeout_pulse === 1'b1) pulses++;
            n_cmp++;
            if (timeout_pulse !== (i == 20)) begin
                n_bad++;
                $display("FAIL timeout_pulse_at_%0d: got %b want %b", i, timeout_pulse, (i == 20));
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL timeout_count: got %0d want 1", pulses);
        end
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 32'h04030201) begin
            n_bad++;
            $display("FAIL timeout_resync: got v=%b d=%h want v=1 d=04030201", m_valid, m_data);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (timeout_pulse !== 1'b0) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL timeout_idle_idx0: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_reset_midop();
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(8'(8'h60 + i));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        send_byte(8'hA1);
        send_byte(8'hA2);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n_cmp++;
        if ({m_valid, m_data, overflow, timeout_pulse} !== 35'd0) begin
            n_bad++;
            $display("FAIL midop_reset: got v=%b d=%h o=%b t=%b want all zero", m_valid, m_data, overflow, timeout_pulse);
        end
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 32'h04030201) begin
            n_bad++;
            $display("FAIL midop_after: got v=%b d=%h want v=1 d=04030201", m_valid, m_data);
        end
        tick();
    endtask

    // Random traffic against a capacity model: up to two finished words can be
    // held (one offered, one waiting); a byte arriving when both are held and
    // nothing leaves this cycle is lost. Words come out in arrival order.
    task automatic test_random();
        logic [31:0] words[$];
        logic [7:0]  part[$];
        logic [7:0]  wb [NB];
        int          held = 0;
        bit          exp_ovf = 1'b0;
        int          quiet = 0;
        bit          xfer;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 500; c++) begin
            n_cmp++;
            if (m_valid !== (held > 0) || overflow !== exp_ovf) begin
                n_bad++;
                $display("FAIL rand_flags_c%0d: got v=%b o=%b want v=%b o=%b", c, m_valid, overflow, (held > 0), exp_ovf);
            end
            if (held > 0) begin
                n_cmp++;
                if (m_data !== words[0]) begin
                    n_bad++;
                    $display("FAIL rand_word_c%0d: got %h want %h", c, m_data, words[0]);
                end
            end
            m_ready = 1'($urandom_range(0, 1));
            s_valid = (quiet >= 5) || ($urandom_range(0, 2) == 0);
            s_data  = 8'($urandom);
            quiet   = s_valid ? 0 : quiet + 1;
            xfer    = (held > 0) && m_ready;
            if (s_valid) begin
                if (held == 2 && !xfer) begin
                    exp_ovf = 1'b1;
                end else begin
                    part.push_back(s_data);
                    if (part.size() == NB) begin
                        for (int i = 0; i < NB; i++) wb[i] = part[i];
                        words.push_back(pack(wb, 1'b1));
                        part.delete();
                        held++;
                    end
                end
            end
            if (xfer) begin
                void'(words.pop_front());
                held--;
            end
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_backpressure();
        test_clr_flags();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_packer.md
Name: uart_rx_packer

Overview:
Sits directly downstream of uart_rx. It consumes that block's byte stream, which is valid-only and has no backpressure. It packs NUM_BYTES consecutive bytes into one wide word and presents the word on a valid/ready master interface to the vector processor datapath. It double-buffers so one full word can wait while the next is collected. An idle timeout resynchronises framing, and overflow is flagged when the consumer stalls too long.

Parameters:
W_BYTE, 8, width of one received byte (matches uart_rx W_OUT)
NUM_BYTES, 4, bytes per packed word; must be >= 2
LSB_FIRST, 1, 1: first byte lands in bits [W_BYTE-1:0]; 0: first byte lands in the MSB slot
TIMEOUT_CLKS, 100000, idle cycles after which a partial word is discarded; 0 disables the timeout

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
s_valid  in  1  byte strobe from uart_rx, single-cycle per byte
s_data  in  W_BYTE  received byte, valid when s_valid=1
m_valid  out  1  packed word available
m_ready  in  1  consumer accepts word when m_valid&m_ready
m_data  out  W_BYTE*NUM_BYTES  packed word, stable while m_valid=1 and m_ready=0
overflow  out  1  sticky: a byte was dropped
timeout_pulse  out  1  one-cycle pulse when a partial word is discarded
clr_flags  in  1  clears overflow

Behaviour:
- Reset (rstn=0 at a clk edge): m_valid=0, m_data=0, overflow=0, timeout_pulse=0, byte index=0, idle counter=0, state=COLLECT. Reset mid-packet discards the partial word, any pending word and the held output word.
- Storage: assembly register (ASM) plus output register (OUT, drives m_data). Byte index idx has width max(1,$clog2(NUM_BYTES)).
- State COLLECT:
  - s_valid=1 writes s_data into ASM slot idx.
  - Slot placement: LSB_FIRST=1 uses bits [idx*W_BYTE +: W_BYTE]; LSB_FIRST=0 uses slot NUM_BYTES-1-idx.
  - idx increments on each accepted byte.
  - On the byte with idx==NUM_BYTES-1, idx wraps to 0:
    - If OUT is free (m_valid=0, or m_valid&m_ready this cycle), the completed word loads into OUT at this edge and m_valid=1 next cycle. Latency is one cycle from the final byte strobe.
    - Otherwise, go to PENDING with the word held in ASM.
- State PENDING:
  - When m_valid&m_ready, the ASM word moves into OUT on the same edge. m_valid stays 1 with no gap, and the state returns to COLLECT.
  - Any s_valid while PENDING: the byte is dropped, idx is unchanged and overflow<=1.
  - s_valid in the same cycle as the transfer: the transfer happens and the byte is accepted as slot 0 of the next word (COLLECT rules apply).
- OUT handshake:
  - m_valid falls the cycle after m_valid&m_ready unless a new word loads on that same edge.
  - m_data never changes while m_valid=1 and m_ready=0.
- Timeout (TIMEOUT_CLKS>0):
  - The idle counter runs only in COLLECT with idx!=0. It clears on every accepted byte and saturates at TIMEOUT_CLKS.
  - On reaching TIMEOUT_CLKS: idx<=0, ASM contents are don't-care, and timeout_pulse=1 for exactly one cycle.
  - s_valid in the expiry cycle: the timeout is applied and the byte is written to slot 0 with idx<=1.
  - Counter width is $clog2(TIMEOUT_CLKS+1).
- clr_flags:
  - clr_flags=1 clears overflow on the next edge.
  - A drop event in the same cycle takes priority, so overflow ends at 1.
- Bytes are never reordered; dropped bytes may misalign later words until the timeout resynchronises framing.

Decomposition:
- Shared package uart_pkg: state enum {COLLECT, PENDING} and a W_BYTE default constant shared with uart_rx/uart_tx.
- One natural sub-module: uart_idle_timer. Inputs: clear, run. Output: expire pulse. Parameter: TIMEOUT_CLKS. Reused later for uart_rx framing-error recovery.
- Everything else is inline.

Test Plan:
- LSB_FIRST=1, m_ready=1, bytes 0x11,0x22,0x33,0x44 -> m_valid=1 exactly one cycle after the 0x44 strobe with m_data=0x44332211, for one cycle only.
- LSB_FIRST=0, same stimulus -> m_data=0x11223344.
- m_ready=0, send 0x01..0x04, then 0x05..0x08, then 0xAA:
  - m_data holds 0x04030201 and the second word is pending.
  - 0xAA is dropped and overflow=1.
  - Raise m_ready for 2 cycles: 0x04030201 then 0x08070605 on consecutive cycles, then m_valid=0.
- TIMEOUT_CLKS=20: send 0xDE,0xAD then idle 20 cycles -> one timeout_pulse. Then send 0x01..0x04 -> m_data=0x04030201. Verify no pulse when idle with idx=0.
- Reset mid-op: send 2 bytes, hold rstn=0 one cycle -> all outputs 0. Then send 0x01..0x04 -> m_data=0x04030201.
- Assert clr_flags in the same cycle a byte is dropped -> overflow stays 1. clr_flags alone on a later cycle -> overflow=0 next cycle.
